// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin data-memory arbiter with bounded port-1 lock
// Grants are combinational; responses are registered one cycle after the grant.
module dmem_arbiter #(
   parameter int AW        = 64,
   parameter int DW        = 64,
   parameter int MEM_BYTES = 32,
   parameter int MAX_LOCK  = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          p0_req,
   input  logic          p0_we,
   input  logic [AW-1:0] p0_adr,
   input  logic [DW-1:0] p0_wdata,
   input  logic          p1_req,
   input  logic          p1_we,
   input  logic [AW-1:0] p1_adr,
   input  logic [DW-1:0] p1_wdata,
   input  logic          p1_lock,
   output logic          p0_gnt,
   output logic          p1_gnt,
   output logic          p0_rvalid,
   output logic          p1_rvalid,
   output logic [DW-1:0] p0_rdata,
   output logic [DW-1:0] p1_rdata,
   output logic          p0_err,
   output logic          p1_err,
   output logic [AW-1:0] mem_adr,
   output logic [DW-1:0] mem_datain,
   output logic          mem_w,
   output logic          mem_r,
   input  logic [DW-1:0] mem_dataout,
   output logic          stall_o
);

   localparam int            LW       = $clog2(MAX_LOCK + 1);
   localparam logic [LW-1:0] LOCK_MAX = LW'(MAX_LOCK);
   localparam logic [AW-1:0] ADR_MAX  = AW'(MEM_BYTES - DW / 8);

   logic          r_last;
   logic [LW-1:0] r_lock_cnt;
   logic          r_p0_rvalid, r_p1_rvalid;
   logic          r_p0_err, r_p1_err;
   logic [DW-1:0] r_p0_rdata, r_p1_rdata;

   logic          w_lock_active;
   logic          w_p0_gnt, w_p1_gnt, w_any_gnt;
   logic          w_we, w_legal, w_acc;
   logic [AW-1:0] w_adr;
   logic [DW-1:0] w_wdata;

   // r_last == 1 means port 1 was granted most recently, so port 0 wins a plain tie.
   assign w_lock_active = (r_lock_cnt != '0) && (r_lock_cnt < LOCK_MAX);
   assign w_p0_gnt      = p0_req & (~p1_req | (~w_lock_active & r_last));
   assign w_p1_gnt      = p1_req & ~w_p0_gnt;
   assign w_any_gnt     = w_p0_gnt | w_p1_gnt;

   assign w_adr   = w_p1_gnt ? p1_adr   : p0_adr;
   assign w_we    = w_p1_gnt ? p1_we    : p0_we;
   assign w_wdata = w_p1_gnt ? p1_wdata : p0_wdata;
   assign w_legal = (w_adr <= ADR_MAX);
   assign w_acc   = w_any_gnt & w_legal;

   assign mem_adr    = w_acc ? w_adr   : '0;
   assign mem_datain = w_acc ? w_wdata : '0;
   assign mem_w      = w_acc & w_we;
   assign mem_r      = w_acc & ~w_we;

   assign p0_gnt    = w_p0_gnt;
   assign p1_gnt    = w_p1_gnt;
   assign stall_o   = p0_req & ~w_p0_gnt;
   assign p0_rvalid = r_p0_rvalid;
   assign p1_rvalid = r_p1_rvalid;
   assign p0_err    = r_p0_err;
   assign p1_err    = r_p1_err;
   assign p0_rdata  = r_p0_rdata;
   assign p1_rdata  = r_p1_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last      <= 1'b1;
         r_lock_cnt  <= '0;
         r_p0_rvalid <= 1'b0;
         r_p1_rvalid <= 1'b0;
         r_p0_err    <= 1'b0;
         r_p1_err    <= 1'b0;
         r_p0_rdata  <= '0;
         r_p1_rdata  <= '0;
      end else begin
         r_p0_rvalid <= w_p0_gnt;
         r_p1_rvalid <= w_p1_gnt;
         r_p0_err    <= w_p0_gnt & ~w_legal;
         r_p1_err    <= w_p1_gnt & ~w_legal;
         r_p0_rdata  <= (w_p0_gnt & mem_r) ? mem_dataout : '0;
         r_p1_rdata  <= (w_p1_gnt & mem_r) ? mem_dataout : '0;
         if (w_p0_gnt) begin
            r_last     <= 1'b0;
            r_lock_cnt <= '0;
         end else if (w_p1_gnt) begin
            r_last <= 1'b1;
            // Saturate so a long solo run of locked port-1 grants never re-arms the lock.
            if (!p1_lock)
               r_lock_cnt <= '0;
            else if (r_lock_cnt != LOCK_MAX)
               r_lock_cnt <= r_lock_cnt + LW'(1);
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with memory model and reference model
module tb_dmem_arbiter;

   localparam int MEM_BYTES = 32;
   localparam int MAX_LOCK  = 4;
   localparam logic [63:0] ADR_MAX = 64'(MEM_BYTES - 8);

   logic        clk = 1'b0;
   logic        rst_n;
   logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
   logic [63:0] p0_adr, p0_wdata, p1_adr, p1_wdata;
   logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
   logic [63:0] p0_rdata, p1_rdata;
   logic [63:0] mem_adr, mem_datain, mem_dataout;
   logic        mem_w, mem_r, stall_o;

   int checks   = 0;
   int failures = 0;

   dmem_arbiter #(.AW(64), .DW(64), .MEM_BYTES(MEM_BYTES), .MAX_LOCK(MAX_LOCK)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_adr(p0_adr), .p0_wdata(p0_wdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_adr(p1_adr), .p1_wdata(p1_wdata),
      .p1_lock(p1_lock),
      .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
      .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
      .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
      .p0_err(p0_err), .p1_err(p1_err),
      .mem_adr(mem_adr), .mem_datain(mem_datain), .mem_w(mem_w), .mem_r(mem_r),
      .mem_dataout(mem_dataout), .stall_o(stall_o)
   );

   always #5 clk = ~clk;

   // Memory device: combinational read, write on the rising edge; reset image byte i = i.
   logic [7:0] dev_mem [0:MEM_BYTES-1];
   logic [7:0] ref_mem [0:MEM_BYTES-1];
   initial for (int i = 0; i < MEM_BYTES; i++) begin
      dev_mem[i] = 8'(i);
      ref_mem[i] = 8'(i);
   end

   always @* begin
      mem_dataout = '0;
      if (mem_adr <= ADR_MAX)
         for (int i = 0; i < 8; i++) mem_dataout[8*i +: 8] = dev_mem[int'(mem_adr[4:0]) + i];
   end

   always @(posedge clk)
      if (mem_w && mem_adr <= ADR_MAX)
         for (int i = 0; i < 8; i++) dev_mem[int'(mem_adr[4:0]) + i] <= mem_datain[8*i +: 8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] ref_read(input logic [63:0] adr);
      logic [63:0] v;
      for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_mem[int'(adr[4:0]) + i];
      return v;
   endfunction

   // Reference model: who was granted last, how many locked port-1 grants in a row, pending responses.
   int          m_last = 1;
   int          m_cnt  = 0;
   logic        e_v0 = 0, e_v1 = 0, e_e0 = 0, e_e1 = 0;
   logic [63:0] e_d0 = 0, e_d1 = 0;

   always @(negedge clk) begin : model
      int          win;
      logic        we, legal;
      logic [63:0] adr, wd;
      if (!rst_n) begin
         m_last = 1; m_cnt = 0;
         e_v0 = 0; e_v1 = 0; e_e0 = 0; e_e1 = 0; e_d0 = 0; e_d1 = 0;
         check("rst_p0_rvalid", 64'(p0_rvalid), 0);
         check("rst_p1_rvalid", 64'(p1_rvalid), 0);
         check("rst_p0_rdata", p0_rdata, 0);
         check("rst_p1_rdata", p1_rdata, 0);
      end else begin
         check("p0_rvalid", 64'(p0_rvalid), 64'(e_v0));
         check("p1_rvalid", 64'(p1_rvalid), 64'(e_v1));
         check("p0_err", 64'(p0_err), 64'(e_e0));
         check("p1_err", 64'(p1_err), 64'(e_e1));
         check("p0_rdata", p0_rdata, e_d0);
         check("p1_rdata", p1_rdata, e_d1);

         if (p0_req && p1_req)
            win = (m_cnt > 0 && m_cnt < MAX_LOCK) ? 1 : 1 - m_last;
         else if (p0_req) win = 0;
         else if (p1_req) win = 1;
         else             win = -1;

         check("p0_gnt", 64'(p0_gnt), 64'(win == 0));
         check("p1_gnt", 64'(p1_gnt), 64'(win == 1));
         check("stall_o", 64'(stall_o), 64'(p0_req && win != 0));

         adr   = (win == 1) ? p1_adr   : p0_adr;
         we    = (win == 1) ? p1_we    : p0_we;
         wd    = (win == 1) ? p1_wdata : p0_wdata;
         legal = (win >= 0) && (adr <= ADR_MAX);

         check("mem_w", 64'(mem_w), 64'(legal && we));
         check("mem_r", 64'(mem_r), 64'(legal && !we));
         if (legal || win < 0) begin
            check("mem_adr", mem_adr, legal ? adr : 64'd0);
            check("mem_datain", mem_datain, legal ? wd : 64'd0);
         end

         e_v0 = (win == 0); e_v1 = (win == 1);
         e_e0 = (win == 0) && !legal; e_e1 = (win == 1) && !legal;
         e_d0 = (win == 0 && legal && !we) ? ref_read(adr) : 64'd0;
         e_d1 = (win == 1 && legal && !we) ? ref_read(adr) : 64'd0;
         if (legal && we)
            for (int i = 0; i < 8; i++) ref_mem[int'(adr[4:0]) + i] = wd[8*i +: 8];
         if (win >= 0) begin
            m_cnt  = (win == 1 && p1_lock) ? m_cnt + 1 : 0;
            m_last = win;
         end
      end
   end

   task automatic set_in(input logic r0, input logic w0, input logic [63:0] a0, input logic [63:0] d0,
                         input logic r1, input logic w1, input logic [63:0] a1, input logic [63:0] d1,
                         input logic l1);
      p0_req = r0; p0_we = w0; p0_adr = a0; p0_wdata = d0;
      p1_req = r1; p1_we = w1; p1_adr = a1; p1_wdata = d1; p1_lock = l1;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   function automatic logic [63:0] rand_adr();
      int k = $urandom_range(0, 9);
      if (k < 7)  return 64'($urandom_range(0, 24));
      if (k < 9)  return 64'($urandom_range(25, 40));
      return {$urandom, $urandom};
   endfunction

   logic [7:0] lock_seq;

   initial begin
      rst_n = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_p0_err", 64'(p0_err), 0);
      check("reset_p1_err", 64'(p1_err), 0);
      check("reset_mem_adr", mem_adr, 0);
      rst_n = 1'b1;

      // Tie straight after reset: port 0 first, port 1 next cycle, both see the reset image.
      set_in(1, 0, 0, 0, 1, 0, 0, 0, 0);
      @(negedge clk);
      check("t2_p0_gnt", 64'(p0_gnt), 1);
      check("t2_p1_gnt", 64'(p1_gnt), 0);
      check("t2_stall", 64'(stall_o), 0);
      step();
      set_in(0, 0, 0, 0, 1, 0, 0, 0, 0);
      @(negedge clk);
      check("t2_p1_gnt2", 64'(p1_gnt), 1);
      check("t2_p0_rdata", p0_rdata, 64'h0706050403020100);
      step();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("t2_p1_rdata", p1_rdata, 64'h0706050403020100);
      step();

      // Port 0 alone: write then read back.
      set_in(1, 1, 8, 64'h1122334455667788, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("t1_w_gnt", 64'(p0_gnt), 1);
      check("t1_mem_w", 64'(mem_w), 1);
      step();
      set_in(1, 0, 8, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("t1_wack_rvalid", 64'(p0_rvalid), 1);
      check("t1_wack_rdata", p0_rdata, 0);
      step();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("t1_rdata", p0_rdata, 64'h1122334455667788);
      check("t1_err", 64'(p0_err), 0);
      step();

      // Lock: port 1 has priority; four locked grants, then port 0, then port 1 again.
      lock_seq = 8'b1110_1111;
      set_in(1, 0, 0, 0, 1, 0, 8, 0, 1);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check("t3_p1_gnt", 64'(p1_gnt), 64'(lock_seq[c]));
         check("t3_stall", 64'(stall_o), 64'(lock_seq[c]));
         step();
      end

      // Range error at 25, legal at 24.
      set_in(0, 0, 0, 0, 1, 0, 25, 0, 0);
      @(negedge clk);
      check("t4_gnt", 64'(p1_gnt), 1);
      check("t4_mem_r_bad", 64'(mem_r), 0);
      step();
      set_in(0, 0, 0, 0, 1, 0, 24, 0, 0);
      @(negedge clk);
      check("t4_err", 64'(p1_err), 1);
      check("t4_rvalid", 64'(p1_rvalid), 1);
      check("t4_rdata", p1_rdata, 0);
      check("t4_mem_r_ok", 64'(mem_r), 1);
      step();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("t4_err_ok", 64'(p1_err), 0);
      check("t4_rdata_ok", p1_rdata, 64'h1f1e1d1c1b1a1918);
      step();

      // Write by port 1, read by port 0 in the next cycle.
      set_in(0, 0, 0, 0, 1, 1, 16, 64'hDEADBEEF00000000, 0);
      step();
      set_in(1, 0, 16, 0, 0, 0, 0, 0, 0);
      step();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("t6_rdata", p0_rdata, 64'hDEADBEEF00000000);
      step();

      // Reset while a read response is showing.
      set_in(1, 0, 16, 0, 0, 0, 0, 0, 0);
      step();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("t5_rvalid_pre", 64'(p0_rvalid), 1);
      #1 rst_n = 1'b0;
      #1;
      check("t5_rvalid_drop", 64'(p0_rvalid), 0);
      check("t5_rdata_drop", p0_rdata, 0);
      step();
      step();
      rst_n = 1'b1;
      set_in(1, 0, 0, 0, 1, 0, 0, 0, 0);
      @(negedge clk);
      check("t5_tie_p0", 64'(p0_gnt), 1);
      step();

      // Randomised traffic checked by the model.
      for (int c = 0; c < 1500; c++) begin
         set_in($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, rand_adr(), {$urandom, $urandom},
                $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, rand_adr(), {$urandom, $urandom},
                $urandom_range(0, 3) != 0);
         step();
      end
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the shared byte-addressed data memory. It lets the pipeline MEM stage (port 0) and the program-loader/debug port (port 1) share the memory's single access port. It does round-robin arbitration with a bounded lock for port 1, range-checks addresses, and returns a registered response one cycle after each grant. It drives the memory's `adr`/`datain`/`w`/`r` inputs directly and raises `stall_o` to freeze the pipeline while port 0 waits.

## Interface
- `AW`, 64: address width.
- `DW`, 64: data width; one access moves `DW/8` little-endian bytes.
- `MEM_BYTES`, 32: memory size in bytes; the highest legal access address is `MEM_BYTES-DW/8`.
- `MAX_LOCK`, 4: maximum consecutive locked grants to port 1.
- `clk`  in  1  clock. Single clock domain; memory writes commit on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `p0_req`, `p1_req`  in  1  access request, held until granted.
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read.
- `p0_adr`, `p1_adr`  in  AW  byte address.
- `p0_wdata`, `p1_wdata`  in  DW  write data.
- `p1_lock`  in  1  port 1 requests to keep ownership on its next request.
- `p0_gnt`, `p1_gnt`  out  1  combinational grant; the access executes in this cycle.
- `p0_rvalid`, `p1_rvalid`  out  1  registered response strobe, one cycle after the grant.
- `p0_rdata`, `p1_rdata`  out  DW  read data; 0 for writes and errors.
- `p0_err`, `p1_err`  out  1  address-range error, qualified by `rvalid`.
- `mem_adr`  out  AW  to memory `adr`.
- `mem_datain`  out  DW  to memory `datain`.
- `mem_w`, `mem_r`  out  1  to memory `w` and `r`.
- `mem_dataout`  in  DW  from memory `dataout`; combinational read.
- `stall_o`  out  1  `p0_req & ~p0_gnt`.

## Operation
- **Grants.** At most one grant per cycle. A request from a single port is granted immediately.
- **Both ports requesting:**
  - If the lock is active (see below), port 1 wins.
  - Otherwise the winner is the port not granted most recently, as recorded in the `last` register.
- **`last` register.** Updates on every grant. Reset value is 1, so port 0 wins the first tie.
- **Lock.** `lock_cnt` (width `clog2(MAX_LOCK+1)`):
  - Increments on each port-1 grant made with `p1_lock=1`.
  - Clears on any port-0 grant, and on any port-1 grant made with `p1_lock=0`.
  - The lock is active when `lock_cnt != 0 && lock_cnt < MAX_LOCK`.
  - When `lock_cnt == MAX_LOCK`, normal round-robin applies, so port 0 gets the next tie.
- **Range check.** An address is legal when `adr <= MEM_BYTES-DW/8`, compared at full `AW` width with no wrap.
  - Legal, granted access: `mem_adr = adr`, `mem_r = ~we`, `mem_w = we`, `mem_datain = wdata`.
  - Illegal, granted access: the grant is still given, `mem_w = mem_r = 0`, and the response has `err = 1` and `rdata = 0`. Memory is untouched.
- **Idle memory outputs.** With no grant: `mem_adr = 0`, `mem_datain = 0`, `mem_w = mem_r = 0`.
- **Response.** Registered at the edge ending the grant cycle: `pX_rvalid = 1`, `pX_err`, and `pX_rdata`.
  - `pX_rdata` is `mem_dataout` for legal reads, 0 otherwise.
  - A write is acknowledged with `rvalid` and `rdata = 0`.
  - Response outputs of the non-granted port are `rvalid = 0` and `rdata = 0`.
- **No backpressure on responses.** The requester must accept `rvalid` in the cycle it is asserted.

## Timing
- Grant latency is 0 cycles, combinational from `req`. Response latency is 1 cycle after the grant.
- Throughput is one access per cycle. Back-to-back grants to the same port give back-to-back `rvalid`.
- A write commits at the grant-cycle edge. A read of the same address by either port in the next cycle returns the new data.
- Reset values: all `rvalid`/`rdata`/`err` = 0, `last = 1`, `lock_cnt = 0`. Combinational outputs follow their inputs.
- Reset asserted mid-operation clears the registered response immediately and asynchronously; the pending response is dropped. A write granted in the same cycle as reset assertion is not guaranteed.
- Reset deasserts synchronously to `clk` in the system. The first grant is possible in the first cycle after deassertion.

## Test plan
1. **Port 0 alone.** p0 write `adr=8`, `wdata=0x1122334455667788`, then p0 read `adr=8` -> gnt in each cycle, `rvalid` next cycle, read `rdata=0x1122334455667788`, `err=0`, `stall_o=0`.
2. **Simultaneous reads after reset.** Both ports read `adr=0` -> p0 granted first, p1 next cycle. `stall_o=0` in cycle 1, `p1_gnt=0` in cycle 1. Both get the reset-image data `0x0706050403020100`.
3. **Lock.** `p1_lock=1` with both requesting continuously for 8 cycles, `MAX_LOCK=4`, p1 already holding priority -> p1 granted 4 cycles in a row, then p0 granted. `stall_o=1` during the locked cycles.
4. **Range error.** p1 read `adr=25` with `MEM_BYTES=32` -> grant, `mem_r=0`, next cycle `p1_rvalid=1`, `p1_err=1`, `rdata=0`. Read `adr=24` -> legal, `err=0`.
5. **Reset mid-response.** `rst_n` low in the cycle after a p0 read grant -> `p0_rvalid` drops to 0 at once. After release, a tie grants p0.
6. **Write/read hazard.** p1 writes `0xDEADBEEF00000000` to `adr=16`; p0 reads `adr=16` the next cycle -> `p0_rdata=0xDEADBEEF00000000`.
